seven_seg_scan_mux: RTL and testbench
=====================================

// Module: seven_seg_scan_mux
// PURPOSE
//  Upstream stage of the sevenSegmentDisplay decoder on multi-digit common-cathode displays.
//  Holds a NUM_DIGITS-wide packed BCD value and time-multiplexes it one digit at a time.
//  Presents the active nibble on digit_bin, which feeds the decoder's bin input.
//  Drives the active-low digit selects and blanks between digits against ghosting.
//  New values are taken through a ready/valid load port and committed only at frame boundaries.
// PARAMETERS
//  NUM_DIGITS    4       digits scanned, index 0 = least significant (rightmost)
//  REFRESH_DIV   50000   clk cycles each digit is driven (>=1)
//  BLANK_CYCLES  16      clk cycles all digits are off between digits (>=1)
// PORTS
//  clk          in   1             single clock, rising edge
//  rst_n        in   1             asynchronous assert, active-low reset
//  load         in   1             valid: bcd_in is offered this cycle
//  bcd_in       in   4*NUM_DIGITS  packed nibbles, [3:0] = digit 0
//  lzb_en       in   1             leading-zero blanking enable (sampled live)
//  load_ready   out  1             high = a load is accepted this cycle
//  digit_bin    out  4             nibble to the decoder; 4'hF = blank
//  digit_sel_n  out  NUM_DIGITS    one-cold digit enable; all ones = all off
//  frame_done   out  1             one-cycle pulse at the end of each full scan
// BEHAVIOUR
//  Reset values:
//   - state=BLANK, idx=0, cnt=0, display=0, pending_valid=0.
//   - load_ready=1, digit_bin=4'hF, digit_sel_n=all ones, frame_done=0.
//  States:
//   - BLANK: cnt counts 0..BLANK_CYCLES-1; at the last count go to DRIVE, cnt=0.
//   - DRIVE: cnt counts 0..REFRESH_DIV-1; at the last count go to BLANK, cnt=0.
//     On that same edge idx advances modulo NUM_DIGITS.
//  Outputs (Moore, decoded from registered state only; no input-to-output paths):
//   - BLANK: digit_sel_n=all ones, digit_bin=4'hF.
//   - DRIVE: digit_sel_n bit idx=0 and all others 1.
//     digit_bin = display nibble idx, or 4'hF when blanked by LZB.
//  Leading-zero blanking (lzb_en=1):
//   - Digit k is blanked if it and every digit above it are 4'h0.
//   - Digit 0 is never blanked.
//   - Nibbles 4'hA..4'hF pass through unchanged; the decoder renders them blank.
//  Load handshake:
//   - load_ready = !pending_valid.
//   - load && load_ready: pending <= bcd_in, pending_valid <= 1.
//   - load while load_ready=0 is ignored; the source must hold the data.
//  Commit:
//   - On the DRIVE->BLANK edge where idx wraps from NUM_DIGITS-1 to 0:
//     if pending_valid, display <= pending and pending_valid <= 0.
//   - The new value first appears in the next DRIVE of digit 0.
//   - No tearing: a frame never mixes the old and new values.
//   - A load on the commit cycle is not accepted, because load_ready=0 that cycle.
//  frame_done: registered; high for the one cycle after the commit edge, whether or not a commit happened.
//  Timing after reset release:
//   - BLANK_CYCLES blank cycles, then digit 0 is driven.
//   - Frame period = NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
//  Reset mid-operation:
//   - All state returns to the reset values immediately (async).
//   - A pending value is discarded.
//  Counter width = $clog2(max(REFRESH_DIV, BLANK_CYCLES)); idx width = $clog2(NUM_DIGITS), min 1.
// STRUCTURE
//  Package seg_disp_pkg:
//   - localparam BLANK_NIBBLE = 4'hF.
//   - State enum {ST_BLANK, ST_DRIVE}.
//   - Function lzb_mask(value, NUM_DIGITS) returning a per-digit blank vector.
//  Sub-module seg_scan_timer:
//   - Holds cnt, state and idx.
//   - Emits the drive, idx and wrap strobe.
//  Top holds the load/pending/display registers and the output decode.
//  The integrator instantiates sevenSegmentDisplay downstream on digit_bin.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; frame = 40 cycles)
//  1. Reset release, no load:
//     - 2 cycles with sel_n=1111, bin=F.
//     - Then sel_n=1110, bin=0 for 8 cycles; 1101, bin=0 follows after 2 blank cycles.
//  2. Load 0x1234, lzb_en=0:
//     - Next frame shows bin 4,3,2,1 on sel_n 1110,1101,1011,0111, each for 8 cycles.
//     - frame_done pulses every 40 cycles.
//  3. lzb_en=1, load 0x0045: digits 3,2 show bin F and digit 1=4, digit 0=5.
//     Then load 0x0000: digit 0 shows 0 and digits 3..1 show F.
//  4. Two loads (0x1111, then 0x2222) inside one frame:
//     - load_ready stays 0 after the first until the commit edge; the second is held.
//     - 0x1111 is displayed for exactly one frame, then 0x2222.
//  5. Load 0x00A9 with lzb_en=1: digit 1 bin=A passes through; digits 3,2 show F.
//  6. Assert rst_n mid-DRIVE of digit 2 with a pending load:
//     - sel_n=1111, bin=F and load_ready=1 in the same cycle.
//     - After release the display shows 0000; the pending value is lost.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared constants, scan state encoding and leading-zero blanking helper
// for the multiplexed seven-segment display path.
package seg_disp_pkg;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  // The blanking helper works on a fixed 16-digit frame; callers zero-extend.
  localparam int MAX_DIGITS = 16;
  localparam int MAX_IDX_W  = 4;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  function automatic logic [MAX_DIGITS-1:0] lzb_mask(
    input logic [4*MAX_DIGITS-1:0] value,
    input int                      num_digits
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
      if (k < num_digits) begin
        all_zero = all_zero && (value[4*k +: 4] == 4'h0);
        mask[k]  = all_zero && (k != 0);
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan sequencer: alternates a blanking gap and a drive window per digit
// and walks the digit index, flagging the edge that closes a full frame.
module seg_scan_timer
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             drive,
  output logic [IDX_W-1:0] idx,
  output logic             wrap
);

  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wrap_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          // Leaving the last digit closes the frame; this edge is the commit point.
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign drive = (state_q == ST_DRIVE);
  assign idx   = idx_q;
  assign wrap  = wrap_d;

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Multi-digit BCD scan multiplexer feeding a seven-segment decoder; new values
// are double-buffered and swapped in only between frames so a frame never tears.
module seven_seg_scan_mux
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    lzb_en,
  output logic                    load_ready,
  output logic [3:0]              digit_bin,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic             drive;
  logic [IDX_W-1:0] idx;
  logic             wrap;

  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IDX_W       (IDX_W)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .drive(drive),
    .idx  (idx),
    .wrap (wrap)
  );

  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pending_valid_q, pending_valid_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d;
  logic                    frame_done_q, frame_done_d;
  logic                    lzb_q, lzb_d;

  always_comb begin
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    display_d       = display_q;
    frame_done_d    = wrap;
    lzb_d           = lzb_en;
    if (load && !pending_valid_q) begin
      pending_d       = bcd_in;
      pending_valid_d = 1'b1;
    end
    if (wrap && pending_valid_q) begin
      display_d       = pending_q;
      pending_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      display_q       <= '0;
      frame_done_q    <= 1'b0;
      lzb_q           <= 1'b0;
    end else begin
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      display_q       <= display_d;
      frame_done_q    <= frame_done_d;
      lzb_q           <= lzb_d;
    end
  end

  // Outputs decode registered state only; lzb_en is registered to keep inputs off the output path.
  logic [4*MAX_DIGITS-1:0] display_ext;
  logic [MAX_DIGITS-1:0]   blank_vec;
  logic [MAX_IDX_W-1:0]    idx_ext;
  logic [3:0]              cur_nibble;
  logic                    cur_blank;

  always_comb begin
    display_ext                   = '0;
    display_ext[4*NUM_DIGITS-1:0] = display_q;
    idx_ext                       = MAX_IDX_W'(idx);
    blank_vec                     = lzb_mask(display_ext, NUM_DIGITS);
    cur_nibble                    = display_ext[{idx_ext, 2'b00} +: 4];
    cur_blank                     = lzb_q && blank_vec[idx_ext];
  end

  always_comb begin
    digit_sel_n = '1;
    digit_bin   = BLANK_NIBBLE;
    if (drive) begin
      digit_sel_n[idx] = 1'b0;
      digit_bin        = cur_blank ? BLANK_NIBBLE : cur_nibble;
    end
  end

  assign load_ready = !pending_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux with a 4-digit, 8-cycle drive, 2-cycle blank scan
// (40-cycle frame); cyc counts clock cycles since the most recent reset release.
module tb_seven_seg_scan_mux;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int SLOT  = RD + BC;
  localparam int FRAME = ND * SLOT;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        load   = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic        lzb_en = 1'b0;
  logic        load_ready;
  logic [3:0]  digit_bin;
  logic [3:0]  digit_sel_n;
  logic        frame_done;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  always #5 clk = ~clk;

  seven_seg_scan_mux #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .bcd_in     (bcd_in),
    .lzb_en     (lzb_en),
    .load_ready (load_ready),
    .digit_bin  (digit_bin),
    .digit_sel_n(digit_sel_n),
    .frame_done (frame_done)
  );

  // Advance one clock; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic exp_blank(input int c);
    return ((c % FRAME) % SLOT) < BC;
  endfunction

  function automatic int exp_slot(input int c);
    return (c % FRAME) / SLOT;
  endfunction

  function automatic logic [3:0] exp_sel(input int c);
    logic [3:0] one;
    one = 4'b0001;
    if (exp_blank(c)) return 4'hF;
    return ~(one << exp_slot(c));
  endfunction

  function automatic logic [3:0] exp_bin(input int c, input logic [15:0] shown);
    if (exp_blank(c)) return 4'hF;
    return shown[4*exp_slot(c) +: 4];
  endfunction

  function automatic logic exp_fd(input int c);
    return (c > 0) && ((c % FRAME) == 0);
  endfunction

  task automatic test_reset();
    logic [15:0] shown;
    rst_n  = 1'b0;
    load   = 1'b0;
    lzb_en = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (digit_sel_n !== 4'hF || digit_bin !== 4'hF) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: sel_n=%b bin=%h, expected sel_n=1111 bin=f", digit_sel_n, digit_bin);
    end
    compared++;
    if (load_ready !== 1'b1 || frame_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: load_ready=%b frame_done=%b, expected 1 0", load_ready, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    shown = 16'h0000;
    while (cyc < 22) begin
      compared++;
      if (digit_sel_n !== exp_sel(cyc) || digit_bin !== exp_bin(cyc, shown)) begin
        mismatched++;
        $display("[TB] FAIL startup_scan cyc=%0d: sel_n=%b bin=%h, expected sel_n=%b bin=%h",
                 cyc, digit_sel_n, digit_bin, exp_sel(cyc), exp_bin(cyc, shown));
      end
      tick();
    end
  endtask

  task automatic test_load_lzb_off();
    logic [15:0] shown;
    lzb_en = 1'b0;
    compared++;
    if (load_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL ready_before_load: load_ready=%b, expected 1", load_ready);
    end
    load   = 1'b1;
    bcd_in = 16'h1234;
    tick();
    load = 1'b0;
    while (cyc < 80) begin
      shown = (cyc < 40) ? 16'h0000 : 16'h1234;
      compared++;
      if (digit_sel_n !== exp_sel(cyc) || digit_bin !== exp_bin(cyc, shown)) begin
        mismatched++;
        $display("[TB] FAIL load_1234 cyc=%0d: sel_n=%b bin=%h, expected sel_n=%b bin=%h",
                 cyc, digit_sel_n, digit_bin, exp_sel(cyc), exp_bin(cyc, shown));
      end
      compared++;
      if (frame_done !== exp_fd(cyc)) begin
        mismatched++;
        $display("[TB] FAIL frame_done cyc=%0d: got %b, expected %b", cyc, frame_done, exp_fd(cyc));
      end
      compared++;
      if (load_ready !== (cyc >= 40)) begin
        mismatched++;
        $display("[TB] FAIL ready_1234 cyc=%0d: got %b, expected %b", cyc, load_ready, (cyc >= 40));
      end
      tick();
    end
  endtask

  task automatic test_lzb();
    logic [15:0] shown;
    lzb_en = 1'b1;
    while (cyc < 200) begin
      if (cyc < 120)      shown = 16'h1234;
      else if (cyc < 160) shown = 16'hFF45;
      else                shown = 16'hFFF0;
      compared++;
      if (digit_sel_n !== exp_sel(cyc) || digit_bin !== exp_bin(cyc, shown)) begin
        mismatched++;
        $display("[TB] FAIL lzb cyc=%0d: sel_n=%b bin=%h, expected sel_n=%b bin=%h",
                 cyc, digit_sel_n, digit_bin, exp_sel(cyc), exp_bin(cyc, shown));
      end
      compared++;
      if (frame_done !== exp_fd(cyc)) begin
        mismatched++;
        $display("[TB] FAIL lzb_frame_done cyc=%0d: got %b, expected %b", cyc, frame_done, exp_fd(cyc));
      end
      load   = (cyc == 80) || (cyc == 120);
      bcd_in = (cyc == 80) ? 16'h0045 : 16'h0000;
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] shown;
    logic        ready_exp;
    while (cyc < 320) begin
      if (cyc < 240)      shown = 16'hFFF0;
      else if (cyc < 280) shown = 16'h1111;
      else                shown = 16'h2222;
      ready_exp = !(((cyc > 200) && (cyc < 240)) || ((cyc > 240) && (cyc < 280)));
      compared++;
      if (digit_sel_n !== exp_sel(cyc) || digit_bin !== exp_bin(cyc, shown)) begin
        mismatched++;
        $display("[TB] FAIL back_to_back cyc=%0d: sel_n=%b bin=%h, expected sel_n=%b bin=%h",
                 cyc, digit_sel_n, digit_bin, exp_sel(cyc), exp_bin(cyc, shown));
      end
      compared++;
      if (load_ready !== ready_exp) begin
        mismatched++;
        $display("[TB] FAIL back_to_back_ready cyc=%0d: got %b, expected %b", cyc, load_ready, ready_exp);
      end
      if (cyc == 200) begin
        load   = 1'b1;
        bcd_in = 16'h1111;
      end else if (cyc >= 205 && cyc <= 240) begin
        load   = 1'b1;
        bcd_in = 16'h2222;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_hex_passthrough();
    logic [15:0] shown;
    while (cyc < 400) begin
      shown = (cyc < 360) ? 16'h2222 : 16'hFFA9;
      compared++;
      if (digit_sel_n !== exp_sel(cyc) || digit_bin !== exp_bin(cyc, shown)) begin
        mismatched++;
        $display("[TB] FAIL hex_passthrough cyc=%0d: sel_n=%b bin=%h, expected sel_n=%b bin=%h",
                 cyc, digit_sel_n, digit_bin, exp_sel(cyc), exp_bin(cyc, shown));
      end
      load   = (cyc == 320);
      bcd_in = 16'h00A9;
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    logic [15:0] shown;
    lzb_en = 1'b0;
    shown  = 16'h00A9;
    while (cyc < 426) begin
      compared++;
      if (digit_sel_n !== exp_sel(cyc) || digit_bin !== exp_bin(cyc, shown)) begin
        mismatched++;
        $display("[TB] FAIL pre_reset cyc=%0d: sel_n=%b bin=%h, expected sel_n=%b bin=%h",
                 cyc, digit_sel_n, digit_bin, exp_sel(cyc), exp_bin(cyc, shown));
      end
      load   = (cyc == 400);
      bcd_in = 16'h5555;
      tick();
    end
    load = 1'b0;
    compared++;
    if (digit_sel_n !== 4'b1011 || load_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL digit2_pending: sel_n=%b load_ready=%b, expected sel_n=1011 load_ready=0",
               digit_sel_n, load_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (digit_sel_n !== 4'hF || digit_bin !== 4'hF || load_ready !== 1'b1 || frame_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: sel_n=%b bin=%h ready=%b fd=%b, expected 1111 f 1 0",
               digit_sel_n, digit_bin, load_ready, frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    shown = 16'h0000;
    while (cyc < 81) begin
      compared++;
      if (digit_sel_n !== exp_sel(cyc) || digit_bin !== exp_bin(cyc, shown)) begin
        mismatched++;
        $display("[TB] FAIL post_reset cyc=%0d: sel_n=%b bin=%h, expected sel_n=%b bin=%h",
                 cyc, digit_sel_n, digit_bin, exp_sel(cyc), exp_bin(cyc, shown));
      end
      compared++;
      if (load_ready !== 1'b1 || frame_done !== exp_fd(cyc)) begin
        mismatched++;
        $display("[TB] FAIL post_reset_flags cyc=%0d: ready=%b fd=%b, expected 1 %b",
                 cyc, load_ready, frame_done, exp_fd(cyc));
      end
      tick();
    end
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_lzb_off();
    test_lzb();
    test_back_to_back();
    test_hex_passthrough();
    test_reset_mid_drive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
